// File: rtl/bcd_display_driver.sv
// bcd_display_driver: sequential double-dabble binary-to-BCD converter driving eight active-low 7-seg digits
// Ports: clk, rst (sync, active-high); bin_in value to show, load start request;
//        busy (state != IDLE), done one-cycle pulse with outputs updated, ovf value above display range;
//        hex0..hex7 segments {g,f,e,d,c,b,a} active-low, hex0 = units, hex7 = most significant
module bcd_display_driver #(
   parameter int IN_W     = 27,
   parameter int DIGITS   = 8,
   parameter int MAX_VAL  = 99999999,
   parameter bit BLANK_LZ = 1'b1,
   parameter bit AUTO     = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] bin_in,
   input  logic            load,
   output logic            busy,
   output logic            done,
   output logic            ovf,
   output logic [6:0]      hex0,
   output logic [6:0]      hex1,
   output logic [6:0]      hex2,
   output logic [6:0]      hex3,
   output logic [6:0]      hex4,
   output logic [6:0]      hex5,
   output logic [6:0]      hex6,
   output logic [6:0]      hex7
);
   // one spare nibble: a full-width input can exceed the displayed digit count
   localparam int BN = DIGITS + 1;
   localparam int CW = $clog2(IN_W);
   localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
   localparam logic [6:0] BLANK = 7'b1111111, ERR = 7'b0000110;
   localparam logic [IN_W-1:0] MAX = IN_W'(MAX_VAL);
   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0: enc = 7'b1000000;
         4'd1: enc = 7'b1111001;
         4'd2: enc = 7'b0100100;
         4'd3: enc = 7'b0110000;
         4'd4: enc = 7'b0011001;
         4'd5: enc = 7'b0010010;
         4'd6: enc = 7'b0000010;
         4'd7: enc = 7'b1111000;
         4'd8: enc = 7'b0000000;
         4'd9: enc = 7'b0010000;
         default: enc = BLANK;
      endcase
   endfunction
   logic [1:0]      state;
   logic [IN_W-1:0] sh, last_val;
   logic [4*BN-1:0] bcd, adj;
   logic [CW-1:0]   cnt;
   logic            last_valid, ovf_cap, start;
   logic [6:0]      seg [DIGITS];
   logic [6:0]      seg_n [DIGITS];
   assign busy = state != IDLE;
   assign start = load | (AUTO & (!last_valid | (bin_in != last_val)));
   assign {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} =
      {seg[7], seg[6], seg[5], seg[4], seg[3], seg[2], seg[1], seg[0]};
   always_comb begin
      for (int i = 0; i < BN; i++)
         adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
   end
   // walk from the top digit down; z stays set while every digit seen so far is zero
   always_comb begin
      logic z;
      z = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         z = z & (bcd[4*i+:4] == 4'd0);
         seg_n[i] = ovf_cap ? (i == 0 ? ERR : BLANK)
                  : (BLANK_LZ && i != 0 && z) ? BLANK : enc(bcd[4*i+:4]);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         done       <= 1'b0;
         ovf        <= 1'b0;
         last_valid <= 1'b0;
         seg        <= '{default: BLANK};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               sh         <= bin_in;
               last_val   <= bin_in;
               last_valid <= 1'b1;
               bcd        <= '0;
               cnt        <= '0;
               ovf_cap    <= bin_in > MAX;
               state      <= SHIFT;
            end
            SHIFT: begin
               {bcd, sh} <= {adj[4*BN-2:0], sh, 1'b0};
               cnt       <= cnt + 1'b1;
               if (cnt == CW'(IN_W - 1)) state <= DONE;
            end
            DONE: begin
               seg   <= seg_n;
               ovf   <= ovf_cap;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
